fir_mac_controller: RTL and testbench

Sequencing and multiply-accumulate stage that consumes the coefficient address counter (6-bit `out`, one-cycle `tc` pulse after wrap) in the FIR filter. It accepts one input sample at a time from the UART-side receiver and stores it in an internal circular sample history. It then drives the address counter through all COEFF_SIZE taps, accumulating coefficient × sample products. The full-precision result goes to the UART transmit side over a valid/ready handshake.

---
 rtl/fir_mac_controller.sv | 123 ++++++++++++
 tb/tb_fir_mac_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_controller.sv
// FIR multiply-accumulate sequencer: stores one sample per request in a circular
// history, walks the external tap counter across all taps, then hands the result downstream.
module fir_mac_controller #(
    parameter int COEFF_SIZE  = 64,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    localparam int ADDR_WIDTH = $clog2(COEFF_SIZE),
    localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + ADDR_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          counter_enable,
    output logic                          counter_reset,
    input  logic        [ADDR_WIDTH-1:0]  counter_out,
    input  logic                          counter_tc,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_WIDTH-1:0]   out_data
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUTPUT
    } state_t;

    state_t state, state_next;

    logic        [ADDR_WIDTH-1:0] wr_ptr;
    logic        [ADDR_WIDTH-1:0] head;
    logic        [ADDR_WIDTH-1:0] tap_idx;
    logic signed [DATA_WIDTH-1:0] hist [COEFF_SIZE];
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  product_ext;

    // Tap k pairs with the sample k inputs ago; the modular subtraction wraps naturally.
    assign tap_idx     = head - counter_out;
    assign product     = hist[tap_idx] * coeff_data;
    assign product_ext = {{ADDR_WIDTH{product[PROD_WIDTH-1]}}, product};

    always_comb begin
        state_next     = state;
        in_ready       = 1'b0;
        counter_reset  = 1'b1;
        counter_enable = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                counter_reset  = 1'b0;
                counter_enable = !counter_tc;
                if (counter_tc) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            head      <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < COEFF_SIZE; i++) begin
                hist[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hist[wr_ptr] <= in_data;
                        head         <= wr_ptr;
                        wr_ptr       <= wr_ptr + ADDR_WIDTH'(1);
                        acc          <= '0;
                    end
                end
                MAC: begin
                    // The tc cycle sees the counter already wrapped to 0, so it must not accumulate.
                    if (!counter_tc) begin
                        acc <= acc + product_ext;
                    end else begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_controller.sv
// Directed bench for fir_mac_controller with a behavioural tap counter and coefficient ROM.
module tb_fir_mac_controller;

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               counter_enable;
    logic               counter_reset;
    logic        [5:0]  counter_out;
    logic               counter_tc;
    logic signed [15:0] coeff_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [37:0] out_data;

    logic signed [15:0] coeff_mem [64];

    int tests = 0;
    int fails = 0;

    fir_mac_controller dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .counter_enable (counter_enable),
        .counter_reset  (counter_reset),
        .counter_out    (counter_out),
        .counter_tc     (counter_tc),
        .coeff_data     (coeff_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Address counter: wraps 63->0 and pulses tc the cycle after the wrap.
    always @(posedge clock) begin
        if (reset || counter_reset) begin
            counter_out <= '0;
            counter_tc  <= 1'b0;
        end else begin
            counter_tc <= counter_enable && (counter_out == 6'd63);
            if (counter_enable) begin
                counter_out <= counter_out + 6'd1;
            end
        end
    end

    assign coeff_data = coeff_mem[counter_out];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic accept(input logic signed [15:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("accept_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Counts negedges from the one after the accept edge until out_valid.
    task automatic expect_result(input logic signed [63:0] exp, input string tag);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_latency"}, n, 65);
        check({tag, "_data"}, out_data, exp);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) coeff_mem[k] = 16'(k + 1);

        do_reset();
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_counter_reset", counter_reset, 1);
        check("rst_counter_enable", counter_enable, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);

        // Impulse response walks out the coefficients, then drops to zero.
        for (int i = 0; i < 65; i++) begin
            accept((i == 0) ? 16'sd1 : 16'sd0);
            expect_result((i < 64) ? (i + 1) : 0, $sformatf("impulse%0d", i));
        end

        // Step of 5 through unit taps; saturates at 64 taps while wr_ptr wraps.
        do_reset();
        for (int k = 0; k < 64; k++) coeff_mem[k] = 16'sd1;
        for (int i = 0; i < 70; i++) begin
            accept(16'sd5);
            expect_result(5 * ((i < 64) ? (i + 1) : 64), $sformatf("step%0d", i));
        end

        // Most negative operands everywhere: each product is 2^30, 64 taps reach 2^36.
        do_reset();
        for (int k = 0; k < 64; k++) coeff_mem[k] = -16'sd32768;
        for (int i = 0; i < 64; i++) begin
            accept(-16'sd32768);
            expect_result(longint'(i + 1) <<< 30, $sformatf("extreme%0d", i));
        end

        // Backpressure: result held, a pending sample waits until the handshake.
        do_reset();
        for (int k = 0; k < 64; k++) coeff_mem[k] = 16'(k + 1);
        out_ready = 1'b0;
        accept(16'sd3);
        expect_result(3, "bp_first");
        in_valid = 1'b1;
        in_data  = 16'sd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
            check($sformatf("bp_hold_data%0d", i), out_data, 3);
            check($sformatf("bp_hold_ready%0d", i), in_ready, 0);
            check($sformatf("bp_hold_cnt_en%0d", i), counter_enable, 0);
        end
        check("bp_cnt_reset", counter_reset, 1);
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        @(negedge clock);
        check("bp_accepted", in_ready, 0);
        in_valid = 1'b0;
        expect_result(13, "bp_second");

        // Reset mid-MAC discards the partial sum and the history.
        do_reset();
        accept(16'sd5);
        begin
            int n = 0;
            while (counter_out != 6'd30 && n < 200) begin
                @(negedge clock);
                n++;
            end
        end
        check("mid_counter", counter_out, 30);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_out_valid", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_counter_reset", counter_reset, 1);
        check("mid_counter_enable", counter_enable, 0);
        check("mid_out_data", out_data, 0);
        accept(16'sd1);
        expect_result(1, "post_reset");
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
